// File: rtl/mdio_responder.sv
// MDIO Clause 22 PHY-side responder: decodes oversampled MDC/MDIO frames onto a 32 x 16-bit register port.
// Build option MDIO_RESP_BCAST_EN: write frames to PHY address 0 are also accepted.
module mdio_responder #(
    parameter logic [4:0] PhyAddr    = 5'd1,
    parameter int         SyncStages = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    logic [SyncStages-1:0] mdc_sync_reg, mdio_sync_reg;
    logic                  mdc_dly_reg;
    logic                  mdc_s, mdio_s, mdc_rise, mdc_fall;

    state_t      state_reg, state_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [5:0]  pre_cnt_reg, pre_cnt_next;
    logic        op_reg, op_next;
    logic [3:0]  phy_sh_reg, phy_sh_next;
    logic [3:0]  reg_sh_reg, reg_sh_next;
    logic        is_read_reg, is_read_next;
    logic        match_reg, match_next;
    logic [14:0] wsh_reg, wsh_next;
    logic [15:0] rsh_reg, rsh_next;
    logic [1:0]  rd_dly_reg;
    logic [4:0]  reg_addr_reg, reg_addr_next;
    logic [15:0] reg_wdata_reg, reg_wdata_next;
    logic        reg_rd_reg, reg_rd_next;
    logic        reg_wr_reg, reg_wr_next;
    logic        frame_err_reg, frame_err_next;
    logic        mdio_out_reg, mdio_out_next;
    logic        mdio_oen_reg, mdio_oen_next;
    logic [4:0]  phy_full;
    logic        bcast_hit;

    assign mdc_s    = mdc_sync_reg[SyncStages-1];
    assign mdio_s   = mdio_sync_reg[SyncStages-1];
    assign mdc_rise = mdc_s & ~mdc_dly_reg;
    assign mdc_fall = ~mdc_s & mdc_dly_reg;
    assign phy_full = {phy_sh_reg, mdio_s};

`ifdef MDIO_RESP_BCAST_EN
    assign bcast_hit = (phy_full == 5'd0) && !is_read_reg;
`else
    assign bcast_hit = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        pre_cnt_next   = pre_cnt_reg;
        op_next        = op_reg;
        phy_sh_next    = phy_sh_reg;
        reg_sh_next    = reg_sh_reg;
        is_read_next   = is_read_reg;
        match_next     = match_reg;
        wsh_next       = wsh_reg;
        rsh_next       = rsh_reg;
        reg_addr_next  = reg_addr_reg;
        reg_wdata_next = reg_wdata_reg;
        reg_rd_next    = 1'b0;
        reg_wr_next    = 1'b0;
        frame_err_next = 1'b0;
        mdio_out_next  = mdio_out_reg;
        mdio_oen_next  = mdio_oen_reg;

        // Read data arrives a fixed two cycles after the read strobe
        if (rd_dly_reg[1]) begin
            rsh_next = reg_rdata;
        end

        if (mdc_rise) begin
            case (state_reg)
                S_IDLE: begin
                    if (mdio_s) begin
                        if (pre_cnt_reg != 6'd32) pre_cnt_next = pre_cnt_reg + 6'd1;
                    end else begin
                        pre_cnt_next = 6'd0;
                        if (pre_cnt_reg == 6'd32) state_next = S_ST;
                    end
                end
                S_ST: begin
                    bit_cnt_next = 4'd0;
                    if (mdio_s) begin
                        state_next = S_OP;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = S_IDLE;
                    end
                end
                S_OP: begin
                    if (bit_cnt_reg == 4'd0) begin
                        op_next      = mdio_s;
                        bit_cnt_next = 4'd1;
                    end else begin
                        bit_cnt_next = 4'd0;
                        // Only 10 (read) and 01 (write) are legal opcodes
                        if (op_reg ^ mdio_s) begin
                            is_read_next = op_reg;
                            state_next   = S_PHYAD;
                        end else begin
                            frame_err_next = 1'b1;
                            state_next     = S_IDLE;
                        end
                    end
                end
                S_PHYAD: begin
                    phy_sh_next = phy_full[3:0];
                    if (bit_cnt_reg == 4'd4) begin
                        bit_cnt_next = 4'd0;
                        match_next   = (phy_full == PhyAddr) || bcast_hit;
                        state_next   = S_REGAD;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                S_REGAD: begin
                    reg_sh_next = {reg_sh_reg[2:0], mdio_s};
                    if (bit_cnt_reg == 4'd4) begin
                        bit_cnt_next  = 4'd0;
                        reg_addr_next = {reg_sh_reg, mdio_s};
                        reg_rd_next   = is_read_reg && match_reg;
                        state_next    = S_TA;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt_reg == 4'd0) begin
                        bit_cnt_next = 4'd1;
                    end else begin
                        bit_cnt_next = 4'd0;
                        state_next   = S_DATA;
                    end
                end
                S_DATA: begin
                    wsh_next = {wsh_reg[13:0], mdio_s};
                    if (bit_cnt_reg == 4'd15) begin
                        bit_cnt_next = 4'd0;
                        state_next   = S_IDLE;
                        if (!is_read_reg && match_reg) begin
                            reg_wdata_next = {wsh_reg, mdio_s};
                            reg_wr_next    = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end else if (mdc_fall) begin
            if (is_read_reg && match_reg) begin
                if (state_reg == S_TA && bit_cnt_reg == 4'd1) begin
                    mdio_oen_next = 1'b0;
                    mdio_out_next = 1'b0;
                end else if (state_reg == S_DATA) begin
                    mdio_out_next = rsh_reg[15];
                    rsh_next      = {rsh_reg[14:0], 1'b0};
                end
            end
            // The fall after the last data bit lands in IDLE and releases the pad
            if (state_reg == S_IDLE) begin
                mdio_oen_next = 1'b1;
                mdio_out_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_sync_reg  <= '0;
            mdio_sync_reg <= '1;
            mdc_dly_reg   <= 1'b0;
            state_reg     <= S_IDLE;
            bit_cnt_reg   <= 4'd0;
            pre_cnt_reg   <= 6'd0;
            op_reg        <= 1'b0;
            phy_sh_reg    <= 4'd0;
            reg_sh_reg    <= 4'd0;
            is_read_reg   <= 1'b0;
            match_reg     <= 1'b0;
            wsh_reg       <= 15'd0;
            rsh_reg       <= 16'd0;
            rd_dly_reg    <= 2'b00;
            reg_addr_reg  <= 5'd0;
            reg_wdata_reg <= 16'd0;
            reg_rd_reg    <= 1'b0;
            reg_wr_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
            mdio_out_reg  <= 1'b1;
            mdio_oen_reg  <= 1'b1;
        end else begin
            mdc_sync_reg  <= {mdc_sync_reg[SyncStages-2:0], mdc};
            mdio_sync_reg <= {mdio_sync_reg[SyncStages-2:0], mdio_in};
            mdc_dly_reg   <= mdc_s;
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            pre_cnt_reg   <= pre_cnt_next;
            op_reg        <= op_next;
            phy_sh_reg    <= phy_sh_next;
            reg_sh_reg    <= reg_sh_next;
            is_read_reg   <= is_read_next;
            match_reg     <= match_next;
            wsh_reg       <= wsh_next;
            rsh_reg       <= rsh_next;
            rd_dly_reg    <= {rd_dly_reg[0], reg_rd_reg};
            reg_addr_reg  <= reg_addr_next;
            reg_wdata_reg <= reg_wdata_next;
            reg_rd_reg    <= reg_rd_next;
            reg_wr_reg    <= reg_wr_next;
            frame_err_reg <= frame_err_next;
            mdio_out_reg  <= mdio_out_next;
            mdio_oen_reg  <= mdio_oen_next;
        end
    end

    assign mdio_out  = mdio_out_reg;
    assign mdio_oen  = mdio_oen_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_rd    = reg_rd_reg;
    assign reg_wr    = reg_wr_reg;
    assign reg_wdata = reg_wdata_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: an MDIO initiator model drives frames; a register-file model and
// an expected-memory reference decide which strobes and read data each frame must produce.
module tb_mdio_responder;

    localparam logic [4:0] PHY = 5'd1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio_in = 1'b1;
    logic        mdio_out, mdio_oen, reg_rd, reg_wr, frame_err;
    logic [4:0]  reg_addr;
    logic [15:0] reg_rdata, reg_wdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] regs_mem [32];
    logic [15:0] exp_mem  [32];
    logic [1:0]  rd_pipe = 2'b00;

    int          rd_cnt = 0, wr_cnt = 0, err_cnt = 0, drive_cycles = 0;
    logic [4:0]  last_rd_addr = 5'd0, last_wr_addr = 5'd0;
    logic [15:0] last_wdata = 16'd0;

    mdio_responder #(.PhyAddr(PHY), .SyncStages(2)) dut (
        .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_in(mdio_in),
        .mdio_out(mdio_out), .mdio_oen(mdio_oen), .reg_addr(reg_addr),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_wr(reg_wr),
        .reg_wdata(reg_wdata), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Register file: data is valid only in the cycle two clocks after reg_rd
    always @(posedge clk) rd_pipe <= {rd_pipe[0], reg_rd};
    assign reg_rdata = rd_pipe[1] ? regs_mem[reg_addr] : ~regs_mem[reg_addr];

    always @(negedge clk) begin
        if (reg_rd) begin rd_cnt++; last_rd_addr = reg_addr; end
        if (reg_wr) begin
            wr_cnt++; last_wr_addr = reg_addr; last_wdata = reg_wdata;
            regs_mem[reg_addr] = reg_wdata;
        end
        if (frame_err) err_cnt++;
        if (!mdio_oen) drive_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit accepts(input bit is_wr, input logic [4:0] phy);
        if (phy == PHY) return 1'b1;
`ifdef MDIO_RESP_BCAST_EN
        if (is_wr && phy == 5'd0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // One MDC period of 16 clk; the initiator samples the bus just before the rise
    task automatic mdc_bit(input logic b, output logic bus, output logic oen_s);
        mdio_in = b;
        repeat (8) @(negedge clk);
        oen_s = mdio_oen;
        bus   = mdio_oen ? mdio_in : mdio_out;
        mdc   = 1'b1;
        repeat (8) @(negedge clk);
        mdc   = 1'b0;
    endtask

    task automatic frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [15:0] wd, input int abort_bit,
                         output logic [15:0] rd_bits, output logic ta2_bus,
                         output logic ta1_oen, output logic end_oen);
        logic [13:0] hdr;
        logic        bus, oe, rd_like;
        hdr     = {2'b01, op, phy, ra};
        rd_like = (op == 2'b10);
        rd_bits = 16'd0;
        end_oen = 1'b1;
        for (int i = 0; i < pre_len; i++) mdc_bit(1'b1, bus, oe);
        for (int i = 13; i >= 0; i--) mdc_bit(hdr[i], bus, oe);
        mdc_bit(1'b1, bus, oe);
        ta1_oen = oe;
        mdc_bit(rd_like ? 1'b1 : 1'b0, bus, oe);
        ta2_bus = bus;
        for (int i = 15; i >= 0; i--) begin
            if (i == abort_bit) begin
                mdio_in = 1'b1;
                repeat (4) @(negedge clk);
                check("drive_before_rst", {31'd0, mdio_oen}, 32'd0);
                rst_n = 1'b0;
                #1;
                check("rst_oen", {31'd0, mdio_oen}, 32'd1);
                check("rst_out", {31'd0, mdio_out}, 32'd1);
                check("rst_strobes", {29'd0, reg_rd, reg_wr, frame_err}, 32'd0);
                check("rst_addr_wdata", {11'd0, reg_addr, reg_wdata}, 32'd0);
                return;
            end
            mdc_bit(rd_like ? 1'b1 : wd[i], bus, oe);
            rd_bits[i] = bus;
        end
        repeat (8) @(negedge clk);
        end_oen = mdio_oen;
    endtask

    task automatic run_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] ra, input logic [15:0] wd);
        int          rd0, wr0, err0, drv0;
        bit          exp_rd, exp_wr, exp_err;
        logic [15:0] rd_bits;
        logic        ta2_bus, ta1_oen, end_oen;
        rd0 = rd_cnt; wr0 = wr_cnt; err0 = err_cnt; drv0 = drive_cycles;
        exp_rd  = (pre_len >= 32) && (op == 2'b10) && accepts(1'b0, phy);
        exp_wr  = (pre_len >= 32) && (op == 2'b01) && accepts(1'b1, phy);
        exp_err = (pre_len >= 32) && (op == 2'b00 || op == 2'b11);
        frame(pre_len, op, phy, ra, wd, -1, rd_bits, ta2_bus, ta1_oen, end_oen);
        $display("frame pre=%0d op=%b phy=%0d reg=%0h wd=%h -> rd=%0d wr=%0d err=%0d rdata=%h",
                 pre_len, op, phy, ra, wd, rd_cnt - rd0, wr_cnt - wr0, err_cnt - err0, rd_bits);
        check("rd_pulses", rd_cnt - rd0, {31'd0, exp_rd});
        check("wr_pulses", wr_cnt - wr0, {31'd0, exp_wr});
        check("err_pulses", err_cnt - err0, {31'd0, exp_err});
        check("end_oen", {31'd0, end_oen}, 32'd1);
        if (exp_wr) begin
            exp_mem[ra] = wd;
            check("wr_addr", {27'd0, last_wr_addr}, {27'd0, ra});
            check("wr_data", {16'd0, last_wdata}, {16'd0, wd});
        end
        if (exp_rd) begin
            check("rd_addr", {27'd0, last_rd_addr}, {27'd0, ra});
            check("ta1_oen", {31'd0, ta1_oen}, 32'd1);
            check("ta2_bus", {31'd0, ta2_bus}, 32'd0);
            check("rd_data", {16'd0, rd_bits}, {16'd0, exp_mem[ra]});
        end else begin
            check("no_drive", drive_cycles - drv0, 32'd0);
        end
    endtask

    initial begin
        logic [15:0] rb;
        logic        t2, t1, eo;
        int          rd0, wr0, err0;
        logic [4:0]  phy_pick [5];

        for (int i = 0; i < 32; i++) begin
            regs_mem[i] = 16'($urandom);
            exp_mem[i]  = regs_mem[i];
        end
        repeat (5) @(negedge clk);
        check("reset_oen_out", {30'd0, mdio_oen, mdio_out}, 32'd3);
        check("reset_strobes", {29'd0, reg_rd, reg_wr, frame_err}, 32'd0);
        check("reset_addr_wdata", {11'd0, reg_addr, reg_wdata}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_frame(32, 2'b01, 5'd1, 5'h03, 16'hBEEF);
        regs_mem[31] = 16'hA5C3;
        exp_mem[31]  = 16'hA5C3;
        run_frame(32, 2'b10, 5'd1, 5'h1F, 16'h0000);
        run_frame(32, 2'b10, 5'd2, 5'h01, 16'h0000);
        run_frame(32, 2'b10, 5'd1, 5'h03, 16'h0000);
        run_frame(31, 2'b01, 5'd1, 5'h04, 16'h5555);
        run_frame(32, 2'b11, 5'd1, 5'h04, 16'h5555);
        run_frame(32, 2'b01, 5'd0, 5'h05, 16'h1234);
        run_frame(32, 2'b10, 5'd0, 5'h05, 16'h0000);
        run_frame(32, 2'b10, 5'd1, 5'h05, 16'h0000);

        phy_pick[0] = 5'd1; phy_pick[1] = 5'd1; phy_pick[2] = 5'd2;
        phy_pick[3] = 5'd0; phy_pick[4] = 5'($urandom);
        for (int n = 0; n < 14; n++) begin
            run_frame(32, ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01,
                      phy_pick[$urandom_range(0, 4)], 5'($urandom_range(0, 7)),
                      16'($urandom));
        end

        // Reset asserted while the responder drives data bit 8 of a read
        regs_mem[9] = 16'hFFFF;
        exp_mem[9]  = 16'hFFFF;
        rd0 = rd_cnt; wr0 = wr_cnt; err0 = err_cnt;
        frame(32, 2'b10, 5'd1, 5'h09, 16'h0000, 8, rb, t2, t1, eo);
        $display("frame read phy=1 reg=9 aborted by reset at data bit 8");
        mdc = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post_rst_rd", rd_cnt - rd0, 32'd1);
        check("post_rst_wr_err", (wr_cnt - wr0) + (err_cnt - err0), 32'd0);
        check("post_rst_oen", {31'd0, mdio_oen}, 32'd1);
        run_frame(32, 2'b10, 5'd1, 5'h09, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
